// File: rtl/instr_fetch_unit_pkg.sv
// Shared widths, encodings and the fetch-state enum for the instruction fetch slice.
package instr_fetch_unit_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP       = '0;
  localparam logic [6:0]         HALT_CODE = 7'h7F;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    DROP      = 2'd2
  } fetchState_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetchEntry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the PC handshake, instruction-memory bus and decode-side stream of the fetch stage.
interface instr_fetch_unit_if
  import instr_fetch_unit_pkg::*;
  ();

  logic               pcStall;
  logic [ADDR_W-1:0]  pcIn;
  logic               halt;
  logic               flush;
  logic               imemReq;
  logic [ADDR_W-1:0]  imemAddr;
  logic [INSTR_W-1:0] imemRdata;
  logic               imemValid;
  logic               idValid;
  logic [ADDR_W-1:0]  idPc;
  logic [INSTR_W-1:0] idInstr;
  logic               idReady;

  modport master (
    input  pcIn, halt, flush, imemRdata, imemValid, idReady,
    output pcStall, imemReq, imemAddr, idValid, idPc, idInstr
  );

  modport slave (
    output pcIn, halt, flush, imemRdata, imemValid, idReady,
    input  pcStall, imemReq, imemAddr, idValid, idPc, idInstr
  );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} entries; flush empties it in one edge.
module instr_fetch_unit_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Flush and reset win over any same-cycle push or pop.
  assign w_push  = rst && !i_flush && i_push && (r_count < CNT_W'(DEPTH));
  assign w_pop   = rst && !i_flush && i_pop && (r_count != '0);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rdPtr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding instruction-memory read, buffered results presented to decode.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master io_fetchBus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetchState_t       r_state;
  logic              r_imemReq;
  logic [ADDR_W-1:0] r_imemAddr;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  fetchEntry_t       w_head;
  fetchEntry_t       w_pushEntry;

  // Issuing only with free space guarantees every response has a slot.
  assign w_issue = rst && (r_state == IDLE) && !io_fetchBus.flush && !io_fetchBus.halt
                   && (w_count < CNT_W'(DEPTH));
  assign w_push  = (r_state == WAIT_RESP) && io_fetchBus.imemValid && !io_fetchBus.flush;
  assign w_pop   = !w_empty && io_fetchBus.idReady;

  assign w_pushEntry = '{pc: r_imemAddr, instr: io_fetchBus.imemRdata};

  instr_fetch_unit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetchEntry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (io_fetchBus.flush),
    .i_wdata (w_pushEntry),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_imemReq  <= 1'b0;
      r_imemAddr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_imemReq  <= 1'b1;
            r_imemAddr <= io_fetchBus.pcIn;
            r_state    <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (io_fetchBus.imemValid) begin
            r_imemReq <= 1'b0;
            r_state   <= IDLE;
          end else if (io_fetchBus.flush) begin
            r_state <= DROP;
          end
        end
        DROP: begin
          if (io_fetchBus.imemValid) begin
            r_imemReq <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_fetchBus.pcStall  = !w_issue;
  assign io_fetchBus.imemReq  = r_imemReq;
  assign io_fetchBus.imemAddr = r_imemAddr;
  assign io_fetchBus.idValid  = !w_empty;
  assign io_fetchBus.idPc     = w_empty ? '0 : w_head.pc;
  assign io_fetchBus.idInstr  = w_empty ? NOP : w_head.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model with adjustable latency plus a PC that obeys pcStall.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  logic clk;
  logic rst;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_fetchBus (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  int memLatency  = 1;
  int cycleCount  = 0;

  logic [ADDR_W-1:0] issuedAddr [$];
  logic [ADDR_W-1:0] poppedPc [$];
  logic [INSTR_W-1:0] poppedInstr [$];
  int poppedCycle [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] memWord(input logic [ADDR_W-1:0] addr);
    return 32'hC0DE_0000 | {16'h0, addr[15:0]};
  endfunction

  // Instruction memory: answers each new request after memLatency cycles.
  initial begin : memModel
    bit busy;
    int cnt;
    logic [ADDR_W-1:0] reqAddr;
    busy = 0;
    cnt = 0;
    reqAddr = '0;
    bus.imemValid = 1'b0;
    bus.imemRdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.imemValid = 1'b0;
      if (!rst) begin
        busy = 0;
      end else begin
        if (busy) begin
          cnt++;
        end else if (bus.imemReq) begin
          busy = 1;
          cnt = 1;
          reqAddr = bus.imemAddr;
          issuedAddr.push_back(reqAddr);
        end
        if (busy && cnt >= memLatency) begin
          bus.imemValid = 1'b1;
          bus.imemRdata = memWord(reqAddr);
          busy = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic haltV, input logic flushV, input logic readyV);
    bus.halt    = haltV;
    bus.flush   = flushV;
    bus.idReady = readyV;
    #1;
  endtask

  // Advance one clock: log decode handshakes and step the PC when it was not stalled.
  task automatic nextCycle();
    logic stallNow;
    #1;
    stallNow = bus.pcStall;
    if (bus.idValid && bus.idReady) begin
      poppedPc.push_back(bus.idPc);
      poppedInstr.push_back(bus.idInstr);
      poppedCycle.push_back(cycleCount);
    end
    @(posedge clk);
    #1;
    if (!stallNow) bus.pcIn = bus.pcIn + 32'd4;
    cycleCount++;
    @(negedge clk);
  endtask

  task automatic resetDut(input logic [ADDR_W-1:0] startPc, input int latency);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) nextCycle();
    issuedAddr.delete();
    poppedPc.delete();
    poppedInstr.delete();
    poppedCycle.delete();
    memLatency = latency;
    bus.pcIn = startPc;
    rst = 1'b1;
  endtask

  initial begin : stimulus
    rst = 1'b0;
    bus.pcIn = '0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset held for three cycles.
    repeat (3) nextCycle();
    #1;
    checkOutput("rst_imemReq", 64'(bus.imemReq), 64'd0);
    checkOutput("rst_idValid", 64'(bus.idValid), 64'd0);
    checkOutput("rst_pcStall", 64'(bus.pcStall), 64'd1);
    checkOutput("rst_idPc", 64'(bus.idPc), 64'd0);
    checkOutput("rst_idInstr", 64'(bus.idInstr), 64'd0);

    // Streaming from pc 0, latency 1, decode always ready.
    rst = 1'b1;
    bus.pcIn = 32'h0;
    memLatency = 1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("first_issue_pcStall", 64'(bus.pcStall), 64'd0);
    for (int i = 0; i < 20 && poppedPc.size() < 3; i++) nextCycle();
    checkOutput("stream_count", 64'(poppedPc.size()), 64'd3);
    checkOutput("stream_pc0", 64'(poppedPc.size() > 0 ? poppedPc[0] : '1), 64'h0);
    checkOutput("stream_in0", 64'(poppedInstr.size() > 0 ? poppedInstr[0] : '1), 64'hC0DE0000);
    checkOutput("stream_pc1", 64'(poppedPc.size() > 1 ? poppedPc[1] : '1), 64'h4);
    checkOutput("stream_in1", 64'(poppedInstr.size() > 1 ? poppedInstr[1] : '1), 64'hC0DE0004);
    checkOutput("stream_pc2", 64'(poppedPc.size() > 2 ? poppedPc[2] : '1), 64'h8);
    checkOutput("stream_in2", 64'(poppedInstr.size() > 2 ? poppedInstr[2] : '1), 64'hC0DE0008);
    checkOutput("stream_gap01",
                64'(poppedCycle.size() > 1 && (poppedCycle[1] - poppedCycle[0]) <= 2), 64'd1);
    checkOutput("stream_gap12",
                64'(poppedCycle.size() > 2 && (poppedCycle[2] - poppedCycle[1]) <= 2), 64'd1);

    // Decode stalled: two fetches fill the FIFO, then the PC must hold.
    resetDut(32'h40, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (8) nextCycle();
    #1;
    checkOutput("full_idValid", 64'(bus.idValid), 64'd1);
    checkOutput("full_pcStall", 64'(bus.pcStall), 64'd1);
    checkOutput("full_imemReq", 64'(bus.imemReq), 64'd0);
    checkOutput("full_issues", 64'(issuedAddr.size()), 64'd2);
    checkOutput("full_pcHeld", 64'(bus.pcIn), 64'h48);
    checkOutput("full_headPc", 64'(bus.idPc), 64'h40);
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10 && poppedPc.size() < 2; i++) nextCycle();
    checkOutput("drain_pc0", 64'(poppedPc.size() > 0 ? poppedPc[0] : '1), 64'h40);
    checkOutput("drain_in0", 64'(poppedInstr.size() > 0 ? poppedInstr[0] : '1), 64'hC0DE0040);
    checkOutput("drain_pc1", 64'(poppedPc.size() > 1 ? poppedPc[1] : '1), 64'h44);
    checkOutput("drain_in1", 64'(poppedInstr.size() > 1 ? poppedInstr[1] : '1), 64'hC0DE0044);

    // Flush while waiting on a latency-3 response: stale word must be dropped.
    resetDut(32'h80, 3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1);
    bus.pcIn = 32'h200;
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("drop_imemReq", 64'(bus.imemReq), 64'd1);
    checkOutput("drop_pcStall", 64'(bus.pcStall), 64'd1);
    for (int i = 0; i < 20 && poppedPc.size() < 1; i++) nextCycle();
    checkOutput("redirect_pc", 64'(poppedPc.size() > 0 ? poppedPc[0] : '1), 64'h200);
    checkOutput("redirect_in", 64'(poppedInstr.size() > 0 ? poppedInstr[0] : '1), 64'hC0DE0200);
    checkOutput("redirect_addr", 64'(issuedAddr.size() > 1 ? issuedAddr[1] : '1), 64'h200);

    // Flush in the same cycle as the response.
    resetDut(32'h300, 2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    nextCycle();
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("flushv_pcStall", 64'(bus.pcStall), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("flushv_idValid", 64'(bus.idValid), 64'd0);
    checkOutput("flushv_imemReq", 64'(bus.imemReq), 64'd0);
    checkOutput("flushv_popped", 64'(poppedPc.size()), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("flushv_idle", 64'(bus.pcStall), 64'd0);

    // Halt raised with a request outstanding.
    resetDut(32'h500, 3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (6) nextCycle();
    #1;
    checkOutput("halt_idValid", 64'(bus.idValid), 64'd1);
    checkOutput("halt_idPc", 64'(bus.idPc), 64'h500);
    checkOutput("halt_idInstr", 64'(bus.idInstr), 64'hC0DE0500);
    checkOutput("halt_imemReq", 64'(bus.imemReq), 64'd0);
    checkOutput("halt_issues", 64'(issuedAddr.size()), 64'd1);
    checkOutput("halt_pcStall", 64'(bus.pcStall), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("unhalt_pcStall", 64'(bus.pcStall), 64'd0);
    nextCycle();
    #1;
    checkOutput("unhalt_imemReq", 64'(bus.imemReq), 64'd1);
    checkOutput("unhalt_imemAddr", 64'(bus.imemAddr), 64'h504);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
